// File: rtl/dmem_responder.sv
// dmem_responder: byte-addressed data memory behind valid/ready request and response channels
module dmem_responder #(
  parameter int DEPTH_BYTES  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int WAW = $clog2(WORDS);
  localparam logic [1:0] CNT_LAST = 2'(READ_LATENCY - 2);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic we_q, we_d;
  logic [2:0] f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic err_q, err_d;
  logic [31:0] mem [WORDS];
  logic accept, enter, we, err;
  logic [31:0] a, rword, ld, wsh;
  logic [2:0] f3;
  logic [32:0] size;
  logic [WAW-1:0] widx;
  logic [4:0] sh;
  logic [3:0] wmask;
  always_comb begin
    a = state_q == IDLE ? req_addr : addr_q;
    we = state_q == IDLE ? req_we : we_q;
    f3 = state_q == IDLE ? req_func3 : f3_q;
    size = f3[1:0] == 2'b00 ? 33'd1 : f3[1:0] == 2'b01 ? 33'd2 : 33'd4;
    err = (f3[1:0] == 2'b11) || (f3[2] && (we || f3[1])) ||
          (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00) ||
          ({1'b0, a} + size > 33'(DEPTH_BYTES));
    widx = a[WAW+1:2];
    sh = {a[1:0], 3'b000};
    rword = mem[widx] >> sh;
    ld = f3[1:0] == 2'b00 ? {{24{rword[7] & ~f3[2]}}, rword[7:0]} :
         f3[1:0] == 2'b01 ? {{16{rword[15] & ~f3[2]}}, rword[15:0]} : rword;
    wmask = (f3[1:0] == 2'b00 ? 4'b0001 : f3[1:0] == 2'b01 ? 4'b0011 : 4'b1111) << a[1:0];
    wsh = req_wdata << sh;
  end
  always_comb begin
    req_ready = state_q == IDLE && !rst;
    rsp_valid = state_q == RESP;
    rsp_rdata = rdata_q;
    rsp_err = err_q;
  end
  assign accept = req_valid && req_ready;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = READ_LATENCY > 1 ? BUSY : RESP;
        cnt_d = '0;
      end
      BUSY: begin
        cnt_d = cnt_q + 2'd1;
        state_d = cnt_q == CNT_LAST ? RESP : BUSY;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    enter = state_d == RESP && state_q != RESP;
    addr_d = accept ? req_addr : addr_q;
    we_d = accept ? req_we : we_q;
    f3_d = accept ? req_func3 : f3_q;
    err_d = enter ? err : err_q;
    rdata_d = enter ? (err || we ? 32'd0 : ld) : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
    addr_q <= addr_d;
    we_q <= we_d;
    f3_q <= f3_d;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (accept && we && !err && wmask[i]) mem[widx][8*i +: 8] <= wsh[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table, hand-written and random checks of two responders (latency 1 and 3)
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][2:0] req_func3;
  int tests = 0, fails = 0;
  byte unsigned mem_m [2][1024];
  typedef struct {
    bit we; bit [2:0] f3; bit [31:0] addr; bit [31:0] wd; bit [31:0] rd; bit er;
  } vec_t;
  dmem_responder #(.DEPTH_BYTES(1024), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_func3(req_func3[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
  dmem_responder #(.DEPTH_BYTES(1024), .READ_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_func3(req_func3[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model(int d, bit we, bit [2:0] f3, bit [31:0] addr, bit [31:0] wd,
                       output bit [31:0] rd, output bit er);
    int size;
    bit ok;
    longint a, v;
    a = longint'(addr);
    size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    ok = (f3 <= 2) || (!we && (f3 == 4 || f3 == 5));
    er = !ok || (a % size != 0) || (a + size > 1024);
    rd = 0;
    if (er) return;
    v = 0;
    for (int i = 0; i < size; i++)
      if (we) mem_m[d][a+i] = 8'(wd >> (8*i));
      else v += longint'(mem_m[d][a+i]) << (8*i);
    if (!we && f3 < 4 && size < 4 && v >= (longint'(1) << (8*size-1))) v -= longint'(1) << (8*size);
    rd = we ? 32'd0 : 32'(v);
  endtask
  task automatic do_req(int d, bit we, bit [2:0] f3, bit [31:0] addr, bit [31:0] wd, int stall,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    logic busy_rr, unstable;
    req_we[d] = we; req_func3[d] = f3; req_addr[d] = addr; req_wdata[d] = wd; req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 20) begin @(negedge clk); n++; end
    chk("accept timeout", 32'(n >= 20), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    busy_rr = 1'b0;
    while (!rsp_valid[d] && lat < 20) begin busy_rr |= req_ready[d]; @(negedge clk); lat++; end
    busy_rr |= req_ready[d];
    rd = rsp_rdata[d];
    er = rsp_err[d];
    unstable = 1'b0;
    if (stall > 0) begin
      rsp_ready[d] = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        unstable |= !rsp_valid[d] || rsp_rdata[d] !== rd || rsp_err[d] !== er;
        busy_rr |= req_ready[d];
      end
      rsp_ready[d] = 1'b1;
    end
    chk("response stable under backpressure", 32'(unstable), 32'd0);
    chk("req_ready low while busy", 32'(busy_rr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid after handshake", 32'(rsp_valid[d]), 32'd0);
    chk("req_ready after handshake", 32'(req_ready[d]), 32'd1);
  endtask
  task automatic run(int d, bit we, bit [2:0] f3, bit [31:0] addr, bit [31:0] wd, int stall);
    logic [31:0] rd;
    logic er;
    int lat;
    bit [31:0] erd;
    bit eer;
    do_req(d, we, f3, addr, wd, stall, rd, er, lat);
    model(d, we, f3, addr, wd, erd, eer);
    chk($sformatf("rdata d%0d we=%0d f3=%0d a=%h", d, we, f3, addr), rd, erd);
    chk($sformatf("err d%0d we=%0d f3=%0d a=%h", d, we, f3, addr), 32'(er), 32'(eer));
    chk($sformatf("latency d%0d", d), 32'(lat), d ? 32'd3 : 32'd1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl [$];
    logic [31:0] rd;
    logic er;
    int lat;
    bit [31:0] erd;
    bit eer;
    bit [31:0] addr;
    int sel;
    tbl.push_back('{1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0});
    tbl.push_back('{0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0});
    tbl.push_back('{0, 3'd0, 32'h13, 32'h0, 32'hFFFFFFDE, 0});
    tbl.push_back('{0, 3'd4, 32'h13, 32'h0, 32'h000000DE, 0});
    tbl.push_back('{0, 3'd1, 32'h10, 32'h0, 32'hFFFFBEEF, 0});
    tbl.push_back('{0, 3'd5, 32'h12, 32'h0, 32'h0000DEAD, 0});
    tbl.push_back('{1, 3'd0, 32'h11, 32'hAABBCC55, 32'h0, 0});
    tbl.push_back('{0, 3'd2, 32'h10, 32'h0, 32'hDEAD55EF, 0});
    tbl.push_back('{1, 3'd1, 32'h12, 32'h99881234, 32'h0, 0});
    tbl.push_back('{0, 3'd2, 32'h10, 32'h0, 32'h123455EF, 0});
    tbl.push_back('{0, 3'd1, 32'h11, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 3'd2, 32'h12, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 3'd2, 32'h3FE, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 3'd3, 32'h10, 32'h0, 32'h0, 1});
    tbl.push_back('{1, 3'd4, 32'h10, 32'h0, 32'h0, 1});
    tbl.push_back('{1, 3'd2, 32'hFFFFFFFC, 32'h0, 32'h0, 1});
    tbl.push_back('{1, 3'd1, 32'h13, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 3'd2, 32'h10, 32'h0, 32'h123455EF, 0});
    tbl.push_back('{1, 3'd1, 32'h3FE, 32'hBBBB7788, 32'h0, 0});
    tbl.push_back('{0, 3'd5, 32'h3FE, 32'h0, 32'h00007788, 0});
    tbl.push_back('{1, 3'd0, 32'h3FF, 32'h00000080, 32'h0, 0});
    tbl.push_back('{0, 3'd0, 32'h3FF, 32'h0, 32'hFFFFFF80, 0});
    tbl.push_back('{0, 3'd1, 32'h3FE, 32'h0, 32'hFFFF8088, 0});
    tbl.push_back('{0, 3'd6, 32'h10, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 3'd0, 32'h400, 32'h0, 32'h0, 1});
    rst = 2'b11; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_func3 = '0;
    rsp_ready = 2'b11;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset req_ready d%0d", d), 32'(req_ready[d]), 32'd0);
      chk($sformatf("reset rsp_valid d%0d", d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("reset rsp_err d%0d", d), 32'(rsp_err[d]), 32'd0);
      chk($sformatf("reset rsp_rdata d%0d", d), rsp_rdata[d], 32'd0);
    end
    rst = 2'b00;
    #1;
    chk("idle req_ready d0", 32'(req_ready[0]), 32'd1);
    chk("idle req_ready d1", 32'(req_ready[1]), 32'd1);
    foreach (tbl[i]) begin
      do_req(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, 0, rd, er, lat);
      model(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, erd, eer);
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d err", i), 32'(er), 32'(tbl[i].er));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
    end
    run(1, 1'b1, 3'd2, 32'h10, 32'hCAFEF00D, 0);
    run(1, 1'b0, 3'd2, 32'h10, 32'h0, 5);
    req_we[1] = 1'b1; req_func3[1] = 3'd2; req_addr[1] = 32'h20; req_wdata[1] = 32'h13572468;
    req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    model(1, 1'b1, 3'd2, 32'h20, 32'h13572468, erd, eer);
    chk("busy rsp_valid", 32'(rsp_valid[1]), 32'd0);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    chk("post-reset rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("post-reset req_ready", 32'(req_ready[1]), 32'd1);
    chk("post-reset rsp_rdata", rsp_rdata[1], 32'd0);
    chk("post-reset rsp_err", 32'(rsp_err[1]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("post-reset rsp_valid stays low", 32'(rsp_valid[1]), 32'd0);
    run(1, 1'b0, 3'd2, 32'h20, 32'h0, 0);
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 'h40; a += 4) run(d, 1'b1, 3'd2, 32'(a), $urandom, 0);
      for (int a = 'h3F0; a < 'h400; a += 4) run(d, 1'b1, 3'd2, 32'(a), $urandom, 0);
      repeat (150) begin
        sel = $urandom_range(0, 9);
        addr = sel < 7 ? 32'($urandom_range(0, 63)) :
               sel < 9 ? 32'($urandom_range(32'h3F0, 32'h403)) : $urandom;
        run(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom,
            $urandom_range(0, 3));
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Byte-addressed data memory that services the load/store requests issued by the core's memory-access stage.
- Replaces a combinational array with a valid/ready request channel and a valid/ready response channel.
- Latency is configurable; alignment, range and func3 are checked.
- One outstanding transaction at a time; sits between the MA stage and the writeback path.

Parameters:
- DEPTH_BYTES, 1024, memory size in bytes; must be a multiple of 4.
- READ_LATENCY, 1, cycles from request acceptance to response valid; legal range 1..4.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_func3  input  3  RV32 load/store func3
- req_wdata  input  32  store data, taken from the low lanes
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_rdata  output  32  formatted load data; 0 for stores and errors
- rsp_err  output  1  access fault

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE; rsp_valid=0, rsp_err=0, rsp_rdata=0, latency counter=0.
  - req_ready=0 while rst is high.
  - Memory contents are not reset.
- FSM states:
  - IDLE: req_ready=1. A handshake (req_valid && req_ready at an edge) latches addr/we/func3/wdata. Next state is BUSY if READ_LATENCY>1, else RESP.
  - BUSY: req_ready=0. Counter increments; moves to RESP once READ_LATENCY-1 BUSY cycles have elapsed.
  - RESP: rsp_valid=1 and response fields are stable. On rsp_ready at an edge: clear rsp_valid, return to IDLE. Holds indefinitely while rsp_ready=0.
- Latency: with READ_LATENCY=L, rsp_valid is first high L cycles after the accepting edge.
- Throughput: at most one request per L+1 cycles when rsp_ready is held high. req_ready rises the cycle after the response handshake.
- Legal func3 values:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
- Error conditions, checked on the latched request:
  - Illegal func3.
  - Misalignment: halfword at an odd address; word at an address not a multiple of 4.
  - Out of range: addr + size > DEPTH_BYTES, using full 32-bit address compare without wrap-around.
- On error: rsp_err=1, rsp_rdata=0, no memory write.
- Loads, little-endian:
  - lb/lh sign-extend from bit 7/15 of the loaded value.
  - lbu/lhu zero-extend.
  - lw returns bytes addr+3..addr as bits 31..0.
  - Data is read from the array when entering RESP.
- Stores: byte lanes written on the accepting edge, little-endian, only when there is no error. Store response has rsp_rdata=0, rsp_err=0.
- Request inputs are ignored outside IDLE; req_valid held high is accepted only once req_ready is high.
- Reset mid-operation: the pending response is discarded. A store already committed at acceptance remains in memory.
- rsp_rdata and rsp_err change only on entry to RESP or on reset.

Test Plan:
- sw 0xDEADBEEF to 0x10, then lw 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; with L=1, rsp_valid is high the cycle after acceptance.
- After the above: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
- sb 0x55 to 0x11, then lw 0x10 -> 0xDEAD55EF. sh 0x1234 to 0x12, then lw 0x10 -> 0x123455EF.
- lh 0x11, lw 0x12, lw 0x3FE (DEPTH_BYTES=1024), func3=011 -> each returns rsp_err=1, rsp_rdata=0. A following lw 0x10 is unchanged.
- Backpressure, L=3: hold rsp_ready=0 for 5 cycles -> rsp_valid rises 3 cycles after acceptance and stays with stable data; req_ready=0 throughout. After rsp_ready=1, req_ready=1 next cycle.
- Assert rst while in BUSY after an sw to 0x20 -> rsp_valid=0 and req_ready=1 the cycle after rst drops. lw 0x20 then returns the stored word.
